sequenciador_de_instrucoes: RTL and testbench
=============================================

# sequenciador_de_instrucoes

Instruction sequencer that sits in front of the processor control logic. It accepts a program as a stream of 9-bit instruction words into an internal program buffer. On command, it replays the buffer, driving the `iin` instruction word and the 2-bit `counter` step phase that the control logic consumes (step 00 latches the instruction; steps 01–11 execute it). It also reports busy and completion to the surrounding testbench or host.

## Interface
- `ADDR_WIDTH`, default 5 — program buffer depth is 2^ADDR_WIDTH words.
- `clock`  in  1  — single clock, rising-edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `load_valid`  in  1  — a program word is offered on `load_data`.
- `load_data`  in  9  — instruction word: {opcode[2:0], rx[2:0], ry[2:0]}.
- `load_ready`  out  1  — sequencer accepts a word this cycle.
- `prog_clear`  in  1  — empty the program buffer (word count := 0).
- `run`  in  1  — start executing the buffered program from address 0.
- `iin`  out  9  — current instruction to the control logic.
- `counter`  out  2  — step phase 00, 01, 10, 11.
- `pc`  out  ADDR_WIDTH  — address of the instruction on `iin`.
- `busy`  out  1  — execution in progress.
- `done`  out  1  — one-cycle pulse at program completion.
- `step`  in  1  — present only with SINGLE_STEP_EN.

## Operation
- Every output is registered. All regs reset asynchronously on `resetn`=0:
  - state=IDLE, `counter`=00, `iin`=9'h000, `pc`=0, `busy`=0, `done`=0, `load_ready`=1, word count=0.
  - Buffer contents are not reset.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - `load_ready` = (count < 2^ADDR_WIDTH).
  - `load_valid`&&`load_ready`: write `load_data` to mem[count], then count+1.
  - When the buffer is full, `load_ready`=0 and offered words are dropped.
  - `prog_clear` sets count to 0. If `prog_clear` and `load_valid` arrive together, the clear wins and the word is discarded.
  - `run` with count>0 moves to EXEC. `run` with count==0 is ignored (no `done`).
  - Priority: `prog_clear` > `run` > load.
- EXEC:
  - `load_ready`=0. `load_valid`, `run` and `prog_clear` are ignored.
  - `counter` cycles 00→01→10→11, one step per cycle.
  - `iin`=mem[`pc`] is valid on the cycle `counter`=00 and is held unchanged through 11.
  - After step 11:
    - if `pc` < count−1: `pc`+1, `counter`=00, next word on `iin`.
    - otherwise: go to DONE.
- DONE:
  - Lasts exactly one cycle: `done`=1, `busy`=0, `counter`=00, `iin` holds the last word.
  - Inputs are ignored. Next state is IDLE.
- Count width is ADDR_WIDTH+1, so a full buffer is distinguishable. `pc` never wraps; execution stops at count−1.
- Reset asserted mid-EXEC: all outputs take their reset values immediately. The program is lost (count=0).

## Timing
- `run` sampled high in IDLE at edge t:
  - Cycle after t: `busy`=1, `counter`=00, `pc`=0, `iin`=mem[0].
  - Instruction k occupies cycles t+1+4k … t+4+4k.
  - `done` pulses in cycle t+4N+1, where N = count. `busy` is low in that cycle.
  - The next `run` is accepted from cycle t+4N+2.
- Load handshake:
  - A word transfers on a rising edge with `load_valid`&&`load_ready` both high.
  - Throughput is one word per cycle.
  - `load_ready` falls in the cycle after the 2^ADDR_WIDTH-th write.
- `busy` rises in the cycle after `run` is accepted and falls when DONE is entered.

## Configuration
- `SEQUENCIADOR_SINGLE_STEP_EN` defined:
  - The `step` input exists.
  - In EXEC, `counter` leaves 00 only on a cycle where `step`=1. Steps 01→10→11→next 00 still advance one per cycle.
  - Each instruction therefore waits at 00 with `iin` stable until released.
  - The `done` timing becomes: `done` pulses one cycle after the final 11.
- Not defined:
  - The `step` port is absent.
  - Free-running behaviour as in Timing.

## Test plan
- Reset, load 3 words 9'h145, 9'h0D3, 9'h180, then pulse `run`:
  - `iin` shows 145/0D3/180 on `counter`=00 at cycles 1/5/9.
  - `pc` reads 0/1/2.
  - `done` pulses at cycle 13.
- Load 32 words (ADDR_WIDTH=5):
  - `load_ready` drops after the 32nd.
  - A 33rd word is ignored; count stays 32.
  - Full replay takes 128 EXEC cycles.
- `run` with an empty buffer: no `busy`, no `done`, all outputs remain at reset values.
- During EXEC, drive `load_valid`, `run` and `prog_clear` high:
  - Execution is unaffected.
  - After `done`, replaying the same program gives an identical `iin` sequence.
- Assert `resetn`=0 while `counter`=10 on the second instruction:
  - Immediately `counter`=00, `iin`=000, `busy`=0.
  - A subsequent `run` does nothing (count=0).
- With `SEQUENCIADOR_SINGLE_STEP_EN`, load 9'h145 and hold `step`=0 for 5 cycles after `run`:
  - `counter` stays 00 with `iin`=145.
  - `step`=1 for one cycle, then `counter` advances 01,10,11 and `done` pulses.

Source files
------------

// File: rtl/sequenciador_de_instrucoes_if.sv
// Host-side bus of the instruction sequencer: program load stream, run control and replay outputs.
// The step input exists only when SEQUENCIADOR_SINGLE_STEP_EN is defined.
interface sequenciador_de_instrucoes_if #(
  parameter int ADDR_WIDTH = 5
);
  logic                  load_valid;
  logic [8:0]            load_data;
  logic                  load_ready;
  logic                  prog_clear;
  logic                  run;
  logic [8:0]            iin;
  logic [1:0]            counter;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  busy;
  logic                  done;
`ifdef SEQUENCIADOR_SINGLE_STEP_EN
  logic                  step;

  modport master (
    output load_valid, load_data, prog_clear, run, step,
    input  load_ready, iin, counter, pc, busy, done
  );
  modport slave (
    input  load_valid, load_data, prog_clear, run, step,
    output load_ready, iin, counter, pc, busy, done
  );
`else
  modport master (
    output load_valid, load_data, prog_clear, run,
    input  load_ready, iin, counter, pc, busy, done
  );
  modport slave (
    input  load_valid, load_data, prog_clear, run,
    output load_ready, iin, counter, pc, busy, done
  );
`endif
endinterface

// File: rtl/sequenciador_de_instrucoes.sv
// Instruction sequencer: buffers a program of 9-bit words, then replays it as iin plus a 4-phase counter.
// Optional feature macro: SEQUENCIADOR_SINGLE_STEP_EN (hold each instruction at phase 00 until step).
module sequenciador_de_instrucoes #(
  parameter int ADDR_WIDTH = 5
) (
  input logic clock,
  input logic resetn,
  sequenciador_de_instrucoes_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t                state_q, state_d;
  logic [8:0]            mem [DEPTH];
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [1:0]            counter_q, counter_d;
  logic [8:0]            iin_q, iin_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  load_ready_q, load_ready_d;
  logic                  mem_we;
  logic                  step_ok;
  logic                  last_instr;
  logic                  start;

`ifdef SEQUENCIADOR_SINGLE_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  // pc is the last valid address once pc+1 reaches the word count
  assign last_instr = !(({1'b0, pc_q} + CNT_ONE) < count_q);
  assign start      = !bus.prog_clear && bus.run && (count_q != '0);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = EXEC;
      EXEC:    if (counter_q == 2'b11 && last_instr) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    pc_d      = pc_q;
    counter_d = counter_q;
    iin_d     = iin_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.prog_clear) begin
          count_d = '0;
        end else if (start) begin
          busy_d    = 1'b1;
          pc_d      = '0;
          counter_d = 2'b00;
          iin_d     = mem[0];
        end else if (bus.load_valid && load_ready_q) begin
          mem_we  = 1'b1;
          count_d = count_q + CNT_ONE;
        end
      end
      EXEC: begin
        // only phase 00 may be held back; the remaining phases always run through
        if (counter_q != 2'b00 || step_ok) begin
          if (counter_q == 2'b11) begin
            counter_d = 2'b00;
            if (last_instr) begin
              busy_d = 1'b0;
              done_d = 1'b1;
            end else begin
              pc_d  = pc_q + PC_ONE;
              iin_d = mem[pc_q + PC_ONE];
            end
          end else begin
            counter_d = counter_q + 2'b01;
          end
        end
      end
      default: ;
    endcase
    load_ready_d = (state_d == IDLE) && (count_d < CNT_FULL);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q      <= '0;
      pc_q         <= '0;
      counter_q    <= 2'b00;
      iin_q        <= 9'h000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      count_q      <= count_d;
      pc_q         <= pc_d;
      counter_q    <= counter_d;
      iin_q        <= iin_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  // Program storage keeps its contents across reset
  always_ff @(posedge clock) begin
    if (mem_we) mem[count_q[ADDR_WIDTH-1:0]] <= bus.load_data;
  end

  assign bus.iin        = iin_q;
  assign bus.counter    = counter_q;
  assign bus.pc         = pc_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.load_ready = load_ready_q;

endmodule

// File: tb/tb_sequenciador_de_instrucoes.sv
// Directed bench for sequenciador_de_instrucoes: load, replay, ignored inputs, reset, full buffer, clear.
module tb_sequenciador_de_instrucoes;
  localparam int AW = 5;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  sequenciador_de_instrucoes_if #(.ADDR_WIDTH(AW)) bus ();
  sequenciador_de_instrucoes #(.ADDR_WIDTH(AW)) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;
  logic [8:0] exp_w [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int e_iin, input int e_ctr, input int e_pc,
                         input int e_busy, input int e_done, input int e_rdy);
    chk({tag, ".iin"},  32'(bus.iin),        e_iin);
    chk({tag, ".ctr"},  32'(bus.counter),    e_ctr);
    chk({tag, ".pc"},   32'(bus.pc),         e_pc);
    chk({tag, ".busy"}, 32'(bus.busy),       e_busy);
    chk({tag, ".done"}, 32'(bus.done),       e_done);
    chk({tag, ".rdy"},  32'(bus.load_ready), e_rdy);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse run and follow the whole replay of n words from exp_w; optionally hammer the inputs meanwhile
  task automatic run_prog(input int n, input bit disturb);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    if (disturb) begin
      bus.load_valid = 1'b1;
      bus.prog_clear = 1'b1;
      bus.run        = 1'b1;
      bus.load_data  = 9'h1FF;
    end
    for (int c = 0; c < 4 * n; c++) begin
      chk_out("exec", int'(exp_w[c / 4]), c % 4, c / 4, 1, 0, 0);
      tick();
    end
    bus.load_valid = 1'b0;
    bus.prog_clear = 1'b0;
    bus.run        = 1'b0;
    chk_out("done", int'(exp_w[n - 1]), 0, n - 1, 0, 1, 0);
    tick();
    chk_out("after", int'(exp_w[n - 1]), 0, n - 1, 0, 0, (n < 32) ? 1 : 0);
  endtask

  initial begin
    resetn         = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 9'h000;
    bus.prog_clear = 1'b0;
    bus.run        = 1'b0;
`ifdef SEQUENCIADOR_SINGLE_STEP_EN
    bus.step       = 1'b1;
`endif
    tick();
    tick();
    chk_out("reset", 0, 0, 0, 0, 0, 1);
    resetn = 1'b1;
    tick();

    // run on an empty buffer is ignored
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("empty_run", 0, 0, 0, 0, 0, 1);
      tick();
    end

    // three-word program
    exp_w[0] = 9'h145;
    exp_w[1] = 9'h0D3;
    exp_w[2] = 9'h180;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.load_data = exp_w[i];
      tick();
      chk("rdy_load3", 32'(bus.load_ready), 32'd1);
    end
    bus.load_valid = 1'b0;
    run_prog(3, 1'b0);
    run_prog(3, 1'b1);
    run_prog(3, 1'b0);

    // asynchronous reset while counter=10 on the second instruction
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    repeat (6) tick();
    chk_out("pre_rst", int'(exp_w[1]), 2, 1, 1, 0, 0);
    resetn = 1'b0;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 0, 1);
    tick();
    resetn = 1'b1;
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("post_rst_run", 0, 0, 0, 0, 0, 1);
      tick();
    end

    // fill all 32 words back to back, then offer a 33rd
    bus.load_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_w[i] = 9'((i * 37 + 5) % 512);
      bus.load_data = exp_w[i];
      tick();
      chk("rdy_fill", 32'(bus.load_ready), (i < 31) ? 32'd1 : 32'd0);
    end
    bus.load_data = 9'h0AA;
    tick();
    chk("rdy_full", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b0;
    run_prog(32, 1'b0);

    // clear beats a simultaneous load; buffer is then empty
    bus.load_valid = 1'b1;
    bus.prog_clear = 1'b1;
    bus.load_data  = 9'h077;
    tick();
    bus.load_valid = 1'b0;
    bus.prog_clear = 1'b0;
    chk("rdy_clear", 32'(bus.load_ready), 32'd1);
    bus.run = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("clr_busy", 32'(bus.busy), 32'd0);
      chk("clr_done", 32'(bus.done), 32'd0);
      tick();
    end

    // single-word program: done five cycles after run
    exp_w[0] = 9'h145;
    bus.load_valid = 1'b1;
    bus.load_data  = exp_w[0];
    tick();
    bus.load_valid = 1'b0;
    run_prog(1, 1'b0);

`ifdef SEQUENCIADOR_SINGLE_STEP_EN
    bus.step = 1'b0;
    bus.run  = 1'b1;
    tick();
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk_out("step_hold", 9'h145, 0, 0, 1, 0, 0);
      tick();
    end
    bus.step = 1'b1;
    tick();
    bus.step = 1'b0;
    chk_out("step_01", 9'h145, 1, 0, 1, 0, 0);
    tick();
    chk_out("step_10", 9'h145, 2, 0, 1, 0, 0);
    tick();
    chk_out("step_11", 9'h145, 3, 0, 1, 0, 0);
    tick();
    chk_out("step_done", 9'h145, 0, 0, 0, 1, 0);
    tick();
    bus.step = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
